rf_access_ctrl: RTL and testbench

- Port controller sitting directly upstream of the 32x32 dual-read register file.
- Turns operand-read requests from decode and result-writeback requests from execute/memory into the register file's READ/WRITE/address/data strobes.
- Rule it enforces: READ and WRITE are never 1 in the same cycle.
- Buffers writebacks in a small queue and returns operand pairs to decode through a valid/ready handshake.

---
 rtl/rf_access_ctrl_if.sv | 53 +++++
 rtl/rf_access_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_rf_access_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_access_ctrl_if.sv
// rf_access_ctrl_if: read, operand, writeback and register-file strobes of rf_access_ctrl.
// slave is the controller's view, master the surrounding pipeline and register file.
interface rf_access_ctrl_if #(
  parameter int DATA_W_BITS = 32,
  parameter int ADDR_BITS   = 5
);
  logic                   RD_VALID;
  logic                   RD_READY;
  logic [ADDR_BITS-1:0]   RD_ADDR1;
  logic [ADDR_BITS-1:0]   RD_ADDR2;
  logic                   OP_VALID;
  logic                   OP_READY;
  logic [DATA_W_BITS-1:0] OP_DATA1;
  logic [DATA_W_BITS-1:0] OP_DATA2;
  logic                   WB_VALID;
  logic                   WB_READY;
  logic [ADDR_BITS-1:0]   WB_ADDR;
  logic [DATA_W_BITS-1:0] WB_DATA;
  logic                   RF_READ;
  logic                   RF_WRITE;
  logic [ADDR_BITS-1:0]   RF_ADDR_R1;
  logic [ADDR_BITS-1:0]   RF_ADDR_R2;
  logic [ADDR_BITS-1:0]   RF_ADDR_W;
  logic [DATA_W_BITS-1:0] RF_DATA_W;
  logic [DATA_W_BITS-1:0] RF_DATA_R1;
  logic [DATA_W_BITS-1:0] RF_DATA_R2;

  modport slave (
    input  RD_VALID, RD_ADDR1, RD_ADDR2,
    input  OP_READY,
    input  WB_VALID, WB_ADDR, WB_DATA,
    input  RF_DATA_R1, RF_DATA_R2,
    output RD_READY,
    output OP_VALID, OP_DATA1, OP_DATA2,
    output WB_READY,
    output RF_READ, RF_WRITE,
    output RF_ADDR_R1, RF_ADDR_R2,
    output RF_ADDR_W, RF_DATA_W
  );

  modport master (
    output RD_VALID, RD_ADDR1, RD_ADDR2,
    output OP_READY,
    output WB_VALID, WB_ADDR, WB_DATA,
    output RF_DATA_R1, RF_DATA_R2,
    input  RD_READY,
    input  OP_VALID, OP_DATA1, OP_DATA2,
    input  WB_READY,
    input  RF_READ, RF_WRITE,
    input  RF_ADDR_R1, RF_ADDR_R2,
    input  RF_ADDR_W, RF_DATA_W
  );
endinterface

// File: rtl/rf_access_ctrl.sv
// rf_access_ctrl: arbitrates operand reads and queued writebacks onto the register file.
// Define RF_WB_BYPASS_EN to forward queued writebacks into reads instead of stalling them.
module rf_access_ctrl #(
  parameter int WQ_DEPTH    = 2,
  parameter int DATA_W_BITS = 32,
  parameter int ADDR_BITS   = 5
) (
  input logic             CLK,
  input logic             RST,
  rf_access_ctrl_if.slave bus
);
  localparam int PW = (WQ_DEPTH > 1) ? $clog2(WQ_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE,
    RD_ISSUE,
    RD_HOLD,
    WR_ISSUE
  } state_t;

  state_t state, state_nx;

  logic [ADDR_BITS-1:0]   q_addr [WQ_DEPTH];
  logic [DATA_W_BITS-1:0] q_data [WQ_DEPTH];
  logic [PW-1:0]          slot   [WQ_DEPTH];
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          count;
  logic [WQ_DEPTH-1:0]    live, hit1, hit2;

  logic [ADDR_BITS-1:0]   addr1_q, addr2_q;
  logic [ADDR_BITS-1:0]   cmp1, cmp2;
  logic [DATA_W_BITS-1:0] op1_q, op2_q;
  logic [DATA_W_BITS-1:0] rd1, rd2;
  logic                   op_valid_q;

  logic q_full, q_empty;
  logic rd_ok, rd_ready, rd_fire;
  logic enq, deq;

  assign q_full   = (count == CW'(WQ_DEPTH));
  assign q_empty  = (count == '0);
  assign enq      = bus.WB_VALID && !q_full
                 && (bus.WB_ADDR != '0);
  assign deq      = (state == WR_ISSUE);
  assign rd_ready = (state == IDLE) && !q_full && rd_ok;
  assign rd_fire  = bus.RD_VALID && rd_ready;

  // Slot k holds the k-th oldest entry; higher k is newer.
  always_comb begin
    for (int k = 0; k < WQ_DEPTH; k++) begin
      slot[k] = rd_ptr + PW'(k);
      live[k] = (CW'(k) < count);
    end
  end

`ifdef RF_WB_BYPASS_EN
  assign cmp1 = addr1_q;
  assign cmp2 = addr2_q;
`else
  assign cmp1 = bus.RD_ADDR1;
  assign cmp2 = bus.RD_ADDR2;
`endif

  always_comb begin
    for (int k = 0; k < WQ_DEPTH; k++) begin
      hit1[k] = live[k] && (cmp1 != '0)
             && (q_addr[slot[k]] == cmp1);
      hit2[k] = live[k] && (cmp2 != '0)
             && (q_addr[slot[k]] == cmp2);
    end
  end

`ifdef RF_WB_BYPASS_EN
  assign rd_ok = 1'b1;

  always_comb begin
    rd1 = bus.RF_DATA_R1;
    rd2 = bus.RF_DATA_R2;
    for (int k = 0; k < WQ_DEPTH; k++) begin
      if (hit1[k]) rd1 = q_data[slot[k]];
      if (hit2[k]) rd2 = q_data[slot[k]];
    end
  end
`else
  assign rd_ok = !(|hit1) && !(|hit2);
  assign rd1   = bus.RF_DATA_R1;
  assign rd2   = bus.RF_DATA_R2;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (q_full)        state_nx = WR_ISSUE;
        else if (rd_fire)  state_nx = RD_ISSUE;
        else if (!q_empty) state_nx = WR_ISSUE;
      end
      RD_ISSUE: state_nx = RD_HOLD;
      RD_HOLD:  if (bus.OP_READY) state_nx = IDLE;
      WR_ISSUE: state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.RD_READY   = rd_ready;
    bus.WB_READY   = !q_full;
    bus.OP_VALID   = op_valid_q;
    bus.OP_DATA1   = op1_q;
    bus.OP_DATA2   = op2_q;
    bus.RF_READ    = 1'b0;
    bus.RF_WRITE   = 1'b0;
    bus.RF_ADDR_R1 = '0;
    bus.RF_ADDR_R2 = '0;
    bus.RF_ADDR_W  = '0;
    bus.RF_DATA_W  = '0;
    unique case (1'b1)
      (state == RD_ISSUE): begin
        bus.RF_READ    = 1'b1;
        bus.RF_ADDR_R1 = addr1_q;
        bus.RF_ADDR_R2 = addr2_q;
      end
      (state == WR_ISSUE): begin
        bus.RF_WRITE  = 1'b1;
        bus.RF_ADDR_W = q_addr[rd_ptr];
        bus.RF_DATA_W = q_data[rd_ptr];
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int k = 0; k < WQ_DEPTH; k++) begin
        q_addr[k] <= '0;
        q_data[k] <= '0;
      end
    end else begin
      if (enq) begin
        q_addr[wr_ptr] <= bus.WB_ADDR;
        q_data[wr_ptr] <= bus.WB_DATA;
        wr_ptr         <= wr_ptr + PW'(1);
      end
      if (deq) rd_ptr <= rd_ptr + PW'(1);
      if (enq && !deq)      count <= count + CW'(1);
      else if (deq && !enq) count <= count - CW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      addr1_q    <= '0;
      addr2_q    <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      op_valid_q <= 1'b0;
    end else begin
      if (rd_fire) begin
        addr1_q <= bus.RD_ADDR1;
        addr2_q <= bus.RD_ADDR2;
      end
      if (state == RD_ISSUE) begin
        op1_q      <= rd1;
        op2_q      <= rd2;
        op_valid_q <= 1'b1;
      end else if (state == RD_HOLD && bus.OP_READY) begin
        op_valid_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_rf_access_ctrl.sv
// tb_rf_access_ctrl: directed and random checks of rf_access_ctrl against
// an architectural register-file model with a pending-writeback list.
module tb_rf_access_ctrl;
  localparam int DEPTH = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rf_access_ctrl_if bus ();

  rf_access_ctrl #(
    .WQ_DEPTH    (DEPTH),
    .DATA_W_BITS (32),
    .ADDR_BITS   (5)
  ) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus)
  );

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wb_t;

  logic [31:0] mem  [32];
  logic [31:0] arch [32];
  wb_t         pend [$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int acc_cyc = 0;
  bit rd_out   = 1'b0;
  bit rd_stall = 1'b0;
  bit wb_stall = 1'b0;
  logic [4:0]  ea1, ea2;
  logic [31:0] ed1, ed2;

  assign bus.RF_DATA_R1 = mem[bus.RF_ADDR_R1];
  assign bus.RF_DATA_R2 = mem[bus.RF_ADDR_R2];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit queued(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    foreach (pend[i]) if (pend[i].a == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [4:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 6));
  endfunction

  // One cycle: check outputs mid-cycle, advance the model over the next edge.
  task automatic step();
    bit  rf, wf, ox;
    wb_t w;
    #1;
    cyc++;
    chk("rw_excl", 32'(bus.RF_READ && bus.RF_WRITE), 32'd0);
    chk("wb_ready", 32'(bus.WB_READY), 32'(pend.size() != DEPTH));
    chk("op_valid", 32'(bus.OP_VALID),
        32'(rd_out && (cyc >= acc_cyc + 2)));
    chk("rf_read", 32'(bus.RF_READ),
        32'(rd_out && (cyc == acc_cyc + 1)));
    chk("wr_spurious", 32'(bus.RF_WRITE && (pend.size() == 0)), 32'd0);
    if (rd_out) chk("rd_ready_busy", 32'(bus.RD_READY), 32'd0);
`ifndef RF_WB_BYPASS_EN
    if (bus.RD_VALID && (queued(bus.RD_ADDR1) || queued(bus.RD_ADDR2)))
      chk("rd_ready_raw", 32'(bus.RD_READY), 32'd0);
`endif
    if (bus.RF_READ) begin
      chk("rf_addr_r1", 32'(bus.RF_ADDR_R1), 32'(ea1));
      chk("rf_addr_r2", 32'(bus.RF_ADDR_R2), 32'(ea2));
    end
    if (bus.OP_VALID) begin
      chk("op_data1", bus.OP_DATA1, ed1);
      chk("op_data2", bus.OP_DATA2, ed2);
    end
    if (bus.RF_WRITE && pend.size() > 0) begin
      chk("rf_addr_w", 32'(bus.RF_ADDR_W), 32'(pend[0].a));
      chk("rf_data_w", bus.RF_DATA_W, pend[0].d);
      mem[bus.RF_ADDR_W] = bus.RF_DATA_W;
      void'(pend.pop_front());
    end
    rf = bus.RD_VALID && bus.RD_READY;
    wf = bus.WB_VALID && bus.WB_READY;
    ox = bus.OP_VALID && bus.OP_READY;
    if (ox) rd_out = 1'b0;
    if (rf) begin
      ea1     = bus.RD_ADDR1;
      ea2     = bus.RD_ADDR2;
      ed1     = arch[ea1];
      ed2     = arch[ea2];
      rd_out  = 1'b1;
      acc_cyc = cyc;
    end
    if (wf && bus.WB_ADDR != 5'd0) begin
      w.a = bus.WB_ADDR;
      w.d = bus.WB_DATA;
      pend.push_back(w);
      arch[w.a] = w.d;
`ifdef RF_WB_BYPASS_EN
      if (rf && ea1 == w.a) ed1 = w.d;
      if (rf && ea2 == w.a) ed2 = w.d;
`endif
    end
    rd_stall = bus.RD_VALID && !rf;
    wb_stall = bus.WB_VALID && !wf;
    @(negedge clk);
  endtask

  task automatic settle(input int n);
    bus.RD_VALID = 1'b0;
    bus.WB_VALID = 1'b0;
    bus.OP_READY = 1'b1;
    repeat (n) step();
  endtask

  task automatic send_wb(input logic [4:0] a, input logic [31:0] d);
    bus.WB_VALID = 1'b1;
    bus.WB_ADDR  = a;
    bus.WB_DATA  = d;
    step();
  endtask

  task automatic do_read(input string tag,
                         input logic [4:0] a1,
                         input logic [4:0] a2);
    bit acc = 1'b0;
    bus.RD_VALID = 1'b1;
    bus.RD_ADDR1 = a1;
    bus.RD_ADDR2 = a2;
    for (int i = 0; i < 12 && !acc; i++) begin
      #1;
      acc = bus.RD_READY;
      step();
      bus.WB_VALID = 1'b0;
    end
    bus.RD_VALID = 1'b0;
    chk({tag, "_accepted"}, 32'(acc), 32'd1);
  endtask

  task automatic wait_op(input string tag);
    bit seen = 1'b0;
    bus.OP_READY = 1'b0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (bus.OP_VALID) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    chk({tag, "_op_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic expect_write(input string tag,
                              input logic [4:0] a,
                              input logic [31:0] d);
    bit seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      #1;
      if (bus.RF_WRITE) begin
        seen = 1'b1;
        chk({tag, "_addr"}, 32'(bus.RF_ADDR_W), 32'(a));
        chk({tag, "_data"}, bus.RF_DATA_W, d);
        chk({tag, "_no_read"}, 32'(bus.RF_READ), 32'd0);
      end
      step();
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic drive_rand();
    if (!rd_stall) begin
      bus.RD_VALID = ($urandom_range(0, 9) < 4);
      bus.RD_ADDR1 = rand_addr();
      bus.RD_ADDR2 = rand_addr();
    end
    if (!wb_stall) begin
      bus.WB_VALID = ($urandom_range(0, 9) < 5);
      bus.WB_ADDR  = rand_addr();
      bus.WB_DATA  = $urandom();
    end
    bus.OP_READY = ($urandom_range(0, 2) != 0);
  endtask

  initial begin
    bit done;
    for (int i = 0; i < 32; i++) mem[i] = (i * 32'h0101_0101) ^ 32'hA500_0000;
    mem[0] = 32'h0BAD_0000;
    mem[3] = 32'h11;
    mem[7] = 32'h22;
    foreach (mem[i]) arch[i] = mem[i];
    bus.RD_VALID = 1'b0;
    bus.RD_ADDR1 = '0;
    bus.RD_ADDR2 = '0;
    bus.OP_READY = 1'b0;
    bus.WB_VALID = 1'b0;
    bus.WB_ADDR  = '0;
    bus.WB_DATA  = '0;

    @(negedge clk);
    #1;
    chk("rst_rd_ready", 32'(bus.RD_READY), 32'd1);
    chk("rst_wb_ready", 32'(bus.WB_READY), 32'd1);
    chk("rst_op_valid", 32'(bus.OP_VALID), 32'd0);
    chk("rst_op_data1", bus.OP_DATA1, 32'd0);
    chk("rst_rf_read", 32'(bus.RF_READ), 32'd0);
    chk("rst_rf_write", 32'(bus.RF_WRITE), 32'd0);
    chk("rst_rf_addr_w", 32'(bus.RF_ADDR_W), 32'd0);
    chk("rst_rf_data_w", bus.RF_DATA_W, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Plain read of R3/R7 held for three cycles.
    do_read("plain", 5'd3, 5'd7);
    #1;
    chk("plain_rf_read", 32'(bus.RF_READ), 32'd1);
    chk("plain_rf_addr1", 32'(bus.RF_ADDR_R1), 32'd3);
    bus.OP_READY = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("plain_hold_valid", 32'(bus.OP_VALID), 32'd1);
      chk("plain_data1", bus.OP_DATA1, 32'h11);
      chk("plain_data2", bus.OP_DATA2, 32'h22);
      step();
    end
    settle(4);

    // Two back-to-back writebacks fill the queue and drain in order.
    send_wb(5'd4, 32'hA);
    send_wb(5'd5, 32'hB);
    bus.WB_VALID = 1'b0;
    #1;
    chk("full_wb_ready", 32'(bus.WB_READY), 32'd0);
    expect_write("drain_first", 5'd4, 32'hA);
    expect_write("drain_second", 5'd5, 32'hB);
    settle(4);

    // Writeback to R0 is dropped; R0 reads the file.
    send_wb(5'd0, 32'hFF);
    settle(4);
    do_read("r0", 5'd0, 5'd3);
    wait_op("r0");
    chk("r0_data1", bus.OP_DATA1, 32'h0BAD_0000);
    chk("r0_data2", bus.OP_DATA2, 32'h11);
    settle(4);

    // Read-after-write on R9 with two queued results.
    send_wb(5'd9, 32'h55);
    bus.WB_ADDR = 5'd9;
    bus.WB_DATA = 32'h66;
    do_read("raw", 5'd9, 5'd9);
    wait_op("raw");
    chk("raw_data1", bus.OP_DATA1, 32'h66);
    chk("raw_data2", bus.OP_DATA2, 32'h66);
    settle(6);
    chk("raw_file", mem[9], 32'h66);

    // Reset in the middle of a queued write.
    send_wb(5'd12, 32'h77);
    send_wb(5'd13, 32'h88);
    bus.WB_VALID = 1'b0;
    #1;
    chk("rst_mid_write_pre", 32'(bus.RF_WRITE), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_rf_write", 32'(bus.RF_WRITE), 32'd0);
    chk("rst_mid_rd_ready", 32'(bus.RD_READY), 32'd1);
    chk("rst_mid_wb_ready", 32'(bus.WB_READY), 32'd1);
    pend.delete();
    rd_out = 1'b0;
    foreach (mem[i]) arch[i] = mem[i];
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_mid_op_valid", 32'(bus.OP_VALID), 32'd0);
    settle(6);

    // Random traffic.
    rd_stall = 1'b0;
    wb_stall = 1'b0;
    repeat (1500) begin
      drive_rand();
      step();
    end

    done = 1'b0;
    bus.RD_VALID = 1'b0;
    bus.WB_VALID = 1'b0;
    bus.OP_READY = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      step();
      done = (pend.size() == 0) && !rd_out;
    end
    chk("final_drain", 32'(done), 32'd1);
    for (int i = 0; i < 32; i++)
      chk($sformatf("final_reg%0d", i), mem[i], arch[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
